// File: rtl/wide_add_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// wide_add_sequencer_pkg
// Shared definitions for the 64-bit sequenced adder: slice geometry, FSM
// state encoding and the operand slice-select helper.
// ---------------------------------------------------------------------------
package wide_add_sequencer_pkg;

  // Slice width is fixed by the carry_select_adder port width.
  localparam int SLICE  = 16;
  localparam int NSLICE = 4;
  localparam int WIDTH  = SLICE * NSLICE;
  localparam int IDX_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Pick slice number i out of a full-width operand.
  function automatic logic [SLICE-1:0] slice_of(input logic [WIDTH-1:0] v,
                                                input logic [IDX_W-1:0] i);
    logic [SLICE-1:0] r;
    r = v[32'(i) * SLICE +: SLICE];
    return r;
  endfunction

endpackage

// File: rtl/wide_add_sequencer_if.sv
// ---------------------------------------------------------------------------
// wide_add_sequencer_if
// Request/result bundle between a requester (master) and the sequenced
// adder (slave).
//   start      request pulse
//   a, b, cin  operands and initial carry, latched on an accepted start
//   busy       operation in progress
//   done       one-cycle pulse, sum/cout final
//   sum, cout  result and carry-out of the top bit
// ---------------------------------------------------------------------------
interface wide_add_sequencer_if;
  import wide_add_sequencer_pkg::*;

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);

endinterface

// File: rtl/wide_add_sequencer_csa.sv
// ---------------------------------------------------------------------------
// carry_select_adder
// 16-bit carry-select adder built from four 4-bit blocks. The lowest block
// ripples directly; each upper block precomputes its sum for carry-in 0 and
// 1 and the incoming block carry selects between them.
//   i0, i1  16-bit addends
//   cin     carry-in
//   out     {carry, sum[15:0]}
// ---------------------------------------------------------------------------
module carry_select_adder (
  input  logic [15:0] i0,
  input  logic [15:0] i1,
  input  logic        cin,
  output logic [16:0] out
);

  localparam int BLK  = 4;
  localparam int NBLK = 4;

  logic [NBLK:0] blk_c;
  logic [15:0]   s;

  assign blk_c[0] = cin;
  assign {blk_c[1], s[BLK-1:0]} = {1'b0, i0[BLK-1:0]} + {1'b0, i1[BLK-1:0]}
                                  + {4'd0, cin};

  for (genvar g = 1; g < NBLK; g++) begin : g_blk
    logic [BLK:0] r0;
    logic [BLK:0] r1;
    // Both candidate results exist before the block carry arrives.
    assign r0 = {1'b0, i0[g*BLK +: BLK]} + {1'b0, i1[g*BLK +: BLK]};
    assign r1 = r0 + 5'd1;
    assign s[g*BLK +: BLK] = blk_c[g] ? r1[BLK-1:0] : r0[BLK-1:0];
    assign blk_c[g+1]      = blk_c[g] ? r1[BLK]     : r0[BLK];
  end

  assign out = {blk_c[NBLK], s};

endmodule

// File: rtl/wide_add_sequencer.sv
// ---------------------------------------------------------------------------
// wide_add_sequencer
// 64-bit adder that reuses one 16-bit carry_select_adder over four cycles,
// least-significant slice first, with the slice carry registered between
// passes.
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  request/result bundle (slave side): start, a, b, cin in;
//        busy, done, sum, cout out (all outputs registered)
// ---------------------------------------------------------------------------
module wide_add_sequencer
  import wide_add_sequencer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  wide_add_sequencer_if.slave  bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             busy_r;
  logic             done_r;

  logic [SLICE-1:0] op_a;
  logic [SLICE-1:0] op_b;
  logic [SLICE:0]   add_out;

  // Operand slice mux feeding the shared adder.
  always_comb begin
    op_a = slice_of(a_q, idx);
    op_b = slice_of(b_q, idx);
  end

  carry_select_adder u_csa (
    .i0  (op_a),
    .i1  (op_b),
    .cin (carry_q),
    .out (add_out)
  );

  // Sequencing FSM, operand latches and result write-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      carry_q <= 1'b0;
      idx     <= {IDX_W{1'b0}};
      sum_r   <= {WIDTH{1'b0}};
      cout_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry_q <= bus.cin;
            idx     <= {IDX_W{1'b0}};
            sum_r   <= {WIDTH{1'b0}};
            cout_r  <= 1'b0;
            state   <= ST_RUN;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end else begin
            state  <= ST_IDLE;
            busy_r <= 1'b0;
            done_r <= 1'b0;
          end
        end
        ST_RUN: begin
          sum_r[32'(idx) * SLICE +: SLICE] <= add_out[SLICE-1:0];
          carry_q <= add_out[SLICE];
          if (idx == LAST_IDX) begin
            cout_r <= add_out[SLICE];
            state  <= ST_DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end else begin
            idx    <= idx + 2'd1;
            busy_r <= 1'b1;
            done_r <= 1'b0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// ---------------------------------------------------------------------------
// tb_wide_add_sequencer
// Self-checking bench for wide_add_sequencer. Expected results come from a
// plain 65-bit addition of the operands and carry-in.
// ---------------------------------------------------------------------------
module tb_wide_add_sequencer;
  import wide_add_sequencer_pkg::*;

  localparam int W = WIDTH;

  logic clk = 1'b0;
  logic rst;
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  wide_add_sequencer_if bus ();

  wide_add_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: full-width sum with the carry-out as bit W.
  function automatic logic [W:0] ref_add(input logic [W-1:0] x,
                                         input logic [W-1:0] y,
                                         input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  function automatic logic [W-1:0] rand64();
    logic [W-1:0] v;
    v = {$urandom(), $urandom()};
    case ($urandom_range(0, 3))
      0: v[31:0] = 32'hFFFF_FFFF;
      1: v = {W{1'b1}};
      default: ;
    endcase
    return v;
  endfunction

  // Issue one operation from a negedge; returns cycles from accept to done
  // (-1 on timeout) and the result seen with done. Ends on the done negedge.
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic c, output int lat,
                       output logic [W-1:0] s, output logic co);
    bus.a = x; bus.b = y; bus.cin = c; bus.start = 1'b1;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    bus.start = 1'b0;
    while (bus.done !== 1'b1 && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    if (bus.done !== 1'b1) lat = -1;
    s  = bus.sum;
    co = bus.cout;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1;                      // rst must win over start
    @(posedge clk);
    @(negedge clk);
    chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy); else pass_cnt++;
    chk_cnt++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b expected 0", bus.done); else pass_cnt++;
    chk_cnt++; if (bus.sum !== 64'h0) $display("FAIL reset_sum: got %h expected 0", bus.sum); else pass_cnt++;
    chk_cnt++; if (bus.cout !== 1'b0) $display("FAIL reset_cout: got %b expected 0", bus.cout); else pass_cnt++;
    rst = 1'b0; bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_priority_busy: got %b expected 0", bus.busy); else pass_cnt++;
  endtask

  task automatic test_single_slice();
    int lat; logic [W-1:0] s; logic co;
    do_op(64'h0000_0000_0000_EC1C, 64'h0000_0000_0000_FF46, 1'b0, lat, s, co);
    chk_cnt++; if (lat !== 4) $display("FAIL single_latency: got %0d expected 4", lat); else pass_cnt++;
    chk_cnt++; if (s !== 64'h0000_0000_0001_EB62) $display("FAIL single_sum: got %h expected 000000000001eb62", s); else pass_cnt++;
    chk_cnt++; if (co !== 1'b0) $display("FAIL single_cout: got %b expected 0", co); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if (bus.done !== 1'b0) $display("FAIL single_done_pulse: got %b expected 0", bus.done); else pass_cnt++;
    chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL single_idle_busy: got %b expected 0", bus.busy); else pass_cnt++;
    chk_cnt++; if (bus.sum !== 64'h0000_0000_0001_EB62) $display("FAIL single_sum_hold: got %h expected 000000000001eb62", bus.sum); else pass_cnt++;
  endtask

  task automatic test_full_ripple();
    int lat; logic [W-1:0] s; logic co;
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, lat, s, co);
    chk_cnt++; if (lat !== 4) $display("FAIL ripple_latency: got %0d expected 4", lat); else pass_cnt++;
    chk_cnt++; if (s !== 64'h0) $display("FAIL ripple_sum: got %h expected 0", s); else pass_cnt++;
    chk_cnt++; if (co !== 1'b1) $display("FAIL ripple_cout: got %b expected 1", co); else pass_cnt++;
  endtask

  task automatic test_carry_in();
    int lat; logic [W-1:0] s; logic co;
    do_op(64'h1D7D_DD83_0160_8000, 64'hDD78_15DD_369E_8000, 1'b1, lat, s, co);
    chk_cnt++; if (s !== 64'hFAF5_F360_37FF_0001) $display("FAIL cin_sum: got %h expected faf5f36037ff0001", s); else pass_cnt++;
    chk_cnt++; if (co !== 1'b0) $display("FAIL cin_cout: got %b expected 0", co); else pass_cnt++;
  endtask

  task automatic test_random();
    int lat; logic [W-1:0] s, x, y; logic co, c; logic [W:0] exp;
    for (int i = 0; i < 24; i++) begin
      x = rand64(); y = rand64(); c = 1'($urandom_range(0, 1));
      if (i % 4 == 3) y = ~x;              // long carry chains
      exp = ref_add(x, y, c);
      do_op(x, y, c, lat, s, co);
      chk_cnt++; if (lat !== 4) $display("FAIL rand_latency[%0d]: got %0d expected 4", i, lat); else pass_cnt++;
      chk_cnt++; if ({co, s} !== exp) $display("FAIL rand_result[%0d]: got %b_%h expected %b_%h", i, co, s, exp[W], exp[W-1:0]); else pass_cnt++;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a1, b1, a2, b2; logic c1, c2;
    logic [W:0] r1, r2;
    logic [11:0] done_seen, busy_seen;
    a1 = rand64(); b1 = rand64(); c1 = 1'b1;
    a2 = rand64(); b2 = rand64(); c2 = 1'b0;
    r1 = ref_add(a1, b1, c1); r2 = ref_add(a2, b2, c2);
    bus.a = a1; bus.b = b1; bus.cin = c1; bus.start = 1'b1;
    @(posedge clk);
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      done_seen[cyc] = bus.done;
      busy_seen[cyc] = bus.busy;
      if (cyc == 4) begin
        chk_cnt++; if ({bus.cout, bus.sum} !== r1) $display("FAIL b2b_first: got %b_%h expected %b_%h", bus.cout, bus.sum, r1[W], r1[W-1:0]); else pass_cnt++;
      end
      if (cyc == 5) begin
        chk_cnt++; if (bus.sum !== 64'h0) $display("FAIL b2b_sum_cleared: got %h expected 0", bus.sum); else pass_cnt++;
      end
      if (cyc == 9) begin
        chk_cnt++; if ({bus.cout, bus.sum} !== r2) $display("FAIL b2b_second: got %b_%h expected %b_%h", bus.cout, bus.sum, r2[W], r2[W-1:0]); else pass_cnt++;
      end
      case (cyc)
        0: begin bus.start = 1'b0; bus.a = ~a1; bus.b = ~b1; bus.cin = 1'b0; end
        1: bus.start = 1'b1;               // ignored: RUN
        2: bus.start = 1'b0;
        3: begin bus.start = 1'b1; bus.a = a2; bus.b = b2; bus.cin = c2; end
        5: begin bus.start = 1'b0; bus.a = ~a2; bus.b = 64'h0; bus.cin = 1'b1; end
        default: ;
      endcase
      @(posedge clk);
    end
    @(negedge clk);
    chk_cnt++; if (done_seen !== 12'h210) $display("FAIL b2b_done_pattern: got %h expected 210", done_seen); else pass_cnt++;
    chk_cnt++; if (busy_seen !== 12'h1EF) $display("FAIL b2b_busy_pattern: got %h expected 1ef", busy_seen); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int lat, seen; logic [W-1:0] s, x, y; logic co; logic [W:0] exp;
    bus.a = 64'h0123_4567_89AB_CDEF; bus.b = 64'hFFFF_0000_FFFF_0000; bus.cin = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_cnt++; if (bus.sum !== 64'h0) $display("FAIL midrst_sum: got %h expected 0", bus.sum); else pass_cnt++;
    chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", bus.busy); else pass_cnt++;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen++;
    end
    chk_cnt++; if (seen !== 0) $display("FAIL midrst_no_done: got %0d expected 0", seen); else pass_cnt++;
    chk_cnt++; if (bus.cout !== 1'b0) $display("FAIL midrst_cout: got %b expected 0", bus.cout); else pass_cnt++;
    x = rand64(); y = rand64();
    exp = ref_add(x, y, 1'b1);
    do_op(x, y, 1'b1, lat, s, co);
    chk_cnt++; if (lat !== 4) $display("FAIL midrst_fresh_latency: got %0d expected 4", lat); else pass_cnt++;
    chk_cnt++; if ({co, s} !== exp) $display("FAIL midrst_fresh_result: got %b_%h expected %b_%h", co, s, exp[W], exp[W-1:0]); else pass_cnt++;
  endtask

  // Hard stop in case a wait outside the bounded loops ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Test sequence.
  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_slice();
    test_full_ripple();
    test_carry_in();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
